timer_tick_sequencer: RTL and testbench
=======================================

Name: timer_tick_sequencer

Overview:
- Avalon-MM master that owns the 16-bit interval-timer slave (6 word registers: status, control, period_l, period_h, snap_l, snap_h).
- Programs the period and starts/stops the counter.
- Services the timer irq by clearing status, then issues a one-cycle tick and counts ticks.
- Performs atomic 32-bit snapshot reads on request.
- Sits between the system-control logic and the timer, so no CPU is needed to keep a periodic tick running.

Parameters:
- TICK_CNT_W, 32, width of tick_count
- AUTO_START, 0, if 1 the block runs a start sequence with AUTO_PERIOD / continuous mode on the first cycle after reset
- AUTO_PERIOD, 50000, tick period in clk cycles used by AUTO_START

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_period  in  32  tick period in clk cycles; sampled on start_req
- cfg_continuous  in  1  1 = periodic, 0 = one-shot; sampled on start_req
- start_req  in  1  single-cycle pulse: (re)program and start
- stop_req  in  1  single-cycle pulse: stop the counter
- snap_req  in  1  single-cycle pulse: capture the live count
- tmr_address  out  3  timer word address
- tmr_chipselect  out  1  timer chipselect
- tmr_write_n  out  1  timer write, active-low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data; registered, valid 1 cycle after address presented
- tmr_irq  in  1  timer interrupt (level)
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_CNT_W  serviced timeouts, wraps to 0
- snap_value  out  32  last captured count
- snap_valid  out  1  one-cycle pulse when snap_value is updated
- running  out  1  timer started and not yet stopped
- busy  out  1  sequence in progress (state not IDLE/RUN)
- cfg_err  out  1  one-cycle pulse: start_req rejected because cfg_period < 2

Behaviour:
- Reset: state IDLE; all outputs 0 except tmr_write_n = 1; all pending flags cleared; latched period = 0.
- Timer slave has no waitrequest: each write completes in the cycle it is presented.
- Idle bus: tmr_chipselect = 0, tmr_write_n = 1, tmr_address = 0, tmr_writedata = 0.
- Requests are pulses, latched into pending flags (start_p, stop_p, snap_p).
  - A flag clears when its sequence starts.
  - A repeat pulse while the flag is set is absorbed.
- start_req:
  - cfg_period < 2: cfg_err pulses the next cycle; no bus activity; start_p is not set.
  - Otherwise: load value L = cfg_period - 1 and cfg_continuous are latched.
- Write sequence, one cycle each, chipselect = 1, write_n = 0:
  - WR_STOP: addr 1, data 0x0008.
  - WR_PL: addr 2, L[15:0].
  - WR_PH: addr 3, L[31:16].
  - WR_CTRL: addr 1, 0x0007 if continuous else 0x0005 (bit0 ITO, bit1 CONT, bit2 START).
  - CLR_ST: addr 0, data 0x0000.
- Read sequence, chipselect = 1, write_n = 1:
  - SNAP_WR: write addr 4 (latches the snapshot).
  - SNAP_RL: read addr 4.
  - SNAP_RH: read addr 5; low half captured from tmr_readdata.
  - SNAP_DONE: bus idle; high half captured from tmr_readdata; snap_value updated, snap_valid = 1.
- Transitions:
  - IDLE --start_p--> WR_STOP -> WR_PL -> WR_PH -> WR_CTRL -> RUN.
  - running is set at the end of WR_CTRL. A period write makes the timer force-reload and stop itself, so WR_CTRL must follow the period writes.
  - RUN priority, evaluated each cycle: tmr_irq > stop_p > start_p > snap_p.
  - RUN --irq--> CLR_ST. tick = 1 and tick_count += 1 in the CLR_ST cycle. Next state is RUN if continuous; otherwise IDLE with running = 0.
  - RUN --stop_p--> WR_STOP -> CLR_ST (no tick) -> IDLE, running = 0.
  - RUN --start_p--> WR_STOP -> WR_PL... (reprogram); tick_count is kept.
  - RUN/IDLE --snap_p--> SNAP_WR -> SNAP_RL -> SNAP_RH -> SNAP_DONE -> return state.
- IDLE handles start_p before snap_p.
- CLR_ST from the stop path never pulses tick.
- tmr_irq is sampled only in RUN.
  - An irq that arrives during a snap sequence is serviced on return to RUN.
  - Exactly one tick is issued per irq assertion. irq drops the cycle after CLR_ST, so CLR_ST never re-enters on the same event.
- tick_count wraps from all-ones to 0 with no flag.
- busy = 1 in every state except IDLE and RUN.
- An asynchronous reset mid-sequence returns the block to IDLE with the bus idle immediately. The timer resets on the same net; no partial write is retried.

Test Plan:
- Reset, then start_req with cfg_period = 100, continuous = 1 -> writes addr 1 = 0x0008, addr 2 = 0x0063, addr 3 = 0x0000, addr 1 = 0x0007 on consecutive cycles; running = 1; tick every 100 cycles; tick_count = 3 after the third irq; each tick accompanied by a write of 0 to addr 0.
- One-shot with cfg_period = 0x0001_0005 -> addr 2 = 0x0004, addr 3 = 0x0001, ctrl = 0x0005; exactly one tick, then running = 0 and state IDLE.
- start_req with cfg_period = 1 -> cfg_err one-cycle pulse, no chipselect, running unchanged.
- snap_req while running with period 1000 -> SNAP sequence completes in 4 cycles; snap_valid pulses once; snap_value is within 1000 cycles' count of the model; addr 4 written exactly once.
- stop_req and snap_req in the same cycle while RUN -> stop sequence first, then snap; running = 0; no tick issued.
- tmr_irq asserted during SNAP_RL -> snap completes, then CLR_ST within 2 cycles of return to RUN; tick_count increments by exactly 1.

Source files
------------

// File: rtl/timer_tick_sequencer.sv
// timer_tick_sequencer: Avalon-MM master that programs the interval timer, services its
// timeouts as counted one-cycle ticks, and performs atomic 32-bit snapshot reads.
module timer_tick_sequencer #(
    parameter int TICK_CNT_W  = 32,
    parameter bit AUTO_START  = 1'b0,
    parameter int AUTO_PERIOD = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_continuous,
    input  logic                  start_req,
    input  logic                  stop_req,
    input  logic                  snap_req,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic [15:0]           tmr_readdata,
    input  logic                  tmr_irq,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [31:0]           snap_value,
    output logic                  snap_valid,
    output logic                  running,
    output logic                  busy,
    output logic                  cfg_err
);
    typedef enum logic [3:0] {
        IDLE, WR_STOP, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST,
        SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE
    } state_t;

    localparam logic [31:0] AUTO_LOAD = AUTO_START ? 32'(AUTO_PERIOD - 1) : 32'd0;

    state_t      state, state_n;
    logic        start_p, stop_p, snap_p, stopping, ret_run, cont, pend_cont;
    logic        cfg_ok, take_start, take_stop, take_snap;
    logic [31:0] load, pend_load, snap_reg;
    logic [15:0] snap_lo;

    assign cfg_ok = cfg_period >= 32'd2;

    // RUN arbitration: irq > stop > start > snap; IDLE only looks at start then snap
    always_comb begin
        take_stop  = state == RUN && !tmr_irq && stop_p;
        take_start = start_p && (state == IDLE || (state == RUN && !tmr_irq && !stop_p));
        take_snap  = snap_p && ((state == IDLE && !start_p) ||
                                (state == RUN && !tmr_irq && !stop_p && !start_p));
        state_n = state;
        case (state)
            IDLE:      state_n = take_start ? WR_STOP : take_snap ? SNAP_WR : IDLE;
            RUN:       state_n = tmr_irq ? CLR_ST : (take_stop || take_start) ? WR_STOP :
                                 take_snap ? SNAP_WR : RUN;
            WR_STOP:   state_n = stopping ? CLR_ST : WR_PL;
            WR_PL:     state_n = WR_PH;
            WR_PH:     state_n = WR_CTRL;
            WR_CTRL:   state_n = RUN;
            CLR_ST:    state_n = (!stopping && cont) ? RUN : IDLE;
            SNAP_WR:   state_n = SNAP_RL;
            SNAP_RL:   state_n = SNAP_RH;
            SNAP_RH:   state_n = SNAP_DONE;
            SNAP_DONE: state_n = ret_run ? RUN : IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        case (state)
            WR_STOP: begin tmr_address = 3'd1; tmr_writedata = 16'h0008; end
            WR_PL:   begin tmr_address = 3'd2; tmr_writedata = load[15:0]; end
            WR_PH:   begin tmr_address = 3'd3; tmr_writedata = load[31:16]; end
            WR_CTRL: begin tmr_address = 3'd1; tmr_writedata = cont ? 16'h0007 : 16'h0005; end
            CLR_ST:  tmr_address = 3'd0;
            SNAP_WR: tmr_address = 3'd4;
            SNAP_RL: begin tmr_address = 3'd4; tmr_write_n = 1'b1; end
            SNAP_RH: begin tmr_address = 3'd5; tmr_write_n = 1'b1; end
            default: begin tmr_chipselect = 1'b0; tmr_write_n = 1'b1; end
        endcase
    end

    assign tick       = state == CLR_ST && !stopping;
    assign busy       = !(state == IDLE || state == RUN);
    assign snap_valid = state == SNAP_DONE;
    assign snap_value = snap_valid ? {tmr_readdata, snap_lo} : snap_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            start_p    <= AUTO_START;
            stop_p     <= 1'b0;
            snap_p     <= 1'b0;
            stopping   <= 1'b0;
            ret_run    <= 1'b0;
            cont       <= 1'b0;
            pend_cont  <= AUTO_START;
            load       <= 32'd0;
            pend_load  <= AUTO_LOAD;
            snap_reg   <= 32'd0;
            snap_lo    <= 16'h0000;
            tick_count <= '0;
            running    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state   <= state_n;
            cfg_err <= start_req && !cfg_ok;
            start_p <= (start_req && cfg_ok) || (start_p && !take_start);
            stop_p  <= stop_req || (stop_p && !take_stop);
            snap_p  <= snap_req || (snap_p && !take_snap);
            // a pending start carries its own copy so a later pulse cannot corrupt a sequence in flight
            if (start_req && cfg_ok) begin
                pend_load <= cfg_period - 32'd1;
                pend_cont <= cfg_continuous;
            end
            if (take_start) begin
                load <= pend_load;
                cont <= pend_cont;
            end
            if (state == RUN || state == IDLE) stopping <= take_stop;
            if (take_snap) ret_run <= state == RUN;
            if (state == SNAP_RH) snap_lo <= tmr_readdata;
            if (snap_valid) snap_reg <= snap_value;
            if (tick) tick_count <= tick_count + TICK_CNT_W'(1);
            if (state == WR_CTRL) running <= 1'b1;
            else if (state == CLR_ST && state_n == IDLE) running <= 1'b0;
        end
    end
endmodule

// File: tb/tb_timer_tick_sequencer.sv
// tb_timer_tick_sequencer: behavioural interval-timer slave plus an expected-bus-op queue,
// checked every cycle, with directed scenarios pinning timing and literal values.
module tb_timer_tick_sequencer;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic        cfg_continuous = 1'b0, start_req = 1'b0, stop_req = 1'b0, snap_req = 1'b0;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect, tmr_write_n, tmr_irq;
    logic [15:0] tmr_writedata, tmr_readdata;
    logic        tick, snap_valid, running, busy, cfg_err;
    logic [31:0] tick_count, snap_value;
    int          checks = 0, errors = 0, irq_events = 0, snaps = 0;

    typedef struct packed {logic [2:0] a; logic w; logic [15:0] d;} op_t;
    op_t exp_q[$];
    op_t cur;

    logic [31:0] tper, tcnt, tsnap;
    logic        trun, tto, tito, tcont;

    always #5 clk = ~clk;

    timer_tick_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .start_req(start_req), .stop_req(stop_req), .snap_req(snap_req),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
        .tick(tick), .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid),
        .running(running), .busy(busy), .cfg_err(cfg_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Interval timer: counts period+1 cycles per timeout; each new timeout expects one status clear
    assign tmr_irq = tto & tito;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tper <= 0; tcnt <= 0; tsnap <= 0; trun <= 0; tto <= 0; tito <= 0; tcont <= 0;
            tmr_readdata <= 0;
        end else begin
            tmr_readdata <= !(tmr_chipselect && tmr_write_n) ? 16'h0 :
                            tmr_address == 3'd4 ? tsnap[15:0] :
                            tmr_address == 3'd5 ? tsnap[31:16] : 16'h0;
            if (trun) begin
                if (tcnt == 0) begin
                    tto <= 1'b1;
                    tcnt <= tper;
                    if (!tcont) trun <= 1'b0;
                    if (!tto && tito) begin
                        irq_events++;
                        exp_q.push_back({3'd0, 1'b1, 16'h0000});
                    end
                end else tcnt <= tcnt - 1;
            end
            if (tmr_chipselect && !tmr_write_n)
                case (tmr_address)
                    3'd0: tto <= 1'b0;
                    3'd1: begin
                        tito <= tmr_writedata[0];
                        tcont <= tmr_writedata[1];
                        if (tmr_writedata[3]) trun <= 1'b0;
                        if (tmr_writedata[2]) begin trun <= 1'b1; tcnt <= tper; end
                    end
                    3'd2: begin tper[15:0] <= tmr_writedata; trun <= 1'b0; end
                    3'd3: begin tper[31:16] <= tmr_writedata; trun <= 1'b0; end
                    3'd4: tsnap <= tcnt;
                    default: ;
                endcase
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (!tmr_chipselect)
                check("bus_idle", {tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 3'd0, 16'h0});
            else if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL bus_unexpected: addr %0d write_n %0b data %0h, required no access",
                         tmr_address, tmr_write_n, tmr_writedata);
            end else begin
                cur = exp_q.pop_front();
                check("bus_op", {tmr_address, tmr_write_n, tmr_writedata}, {cur.a, !cur.w, cur.d});
            end
            if (tick) begin
                check("tick_count_model", tick_count + 32'd1, 32'(irq_events));
                check("tick_clr_write", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b0, 3'd0});
            end
            if (snap_valid) begin
                snaps++;
                check("snap_value_model", snap_value, tsnap);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = 0;
        while (!tick && n < bound) begin cyc(1); n++; end
        check("tick_seen", tick, 1'b1);
    endtask

    task automatic push_snap();
        exp_q.push_back({3'd4, 1'b1, 16'h0});
        exp_q.push_back({3'd4, 1'b0, 16'h0});
        exp_q.push_back({3'd5, 1'b0, 16'h0});
    endtask

    task automatic start_lit(input logic [31:0] p, input logic c,
                             input logic [15:0] pl, input logic [15:0] ph, input logic [15:0] ctl);
        logic [31:0] l;
        l = p - 32'd1;
        exp_q.push_back({3'd1, 1'b1, 16'h0008});
        exp_q.push_back({3'd2, 1'b1, l[15:0]});
        exp_q.push_back({3'd3, 1'b1, l[31:16]});
        exp_q.push_back({3'd1, 1'b1, c ? 16'h0007 : 16'h0005});
        cfg_period = p; cfg_continuous = c; start_req = 1'b1;
        cyc(1);
        start_req = 1'b0;
        cyc(1); check("wr_stop", {tmr_address, tmr_writedata}, {3'd1, 16'h0008});
        cyc(1); check("wr_pl", {tmr_address, tmr_writedata}, {3'd2, pl});
        cyc(1); check("wr_ph", {tmr_address, tmr_writedata}, {3'd3, ph});
        cyc(1); check("wr_ctrl", {tmr_address, tmr_writedata, busy, running}, {3'd1, ctl, 2'b10});
        cyc(1); check("running_after_ctrl", {running, busy}, 2'b10);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] tc0;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        check("reset_outputs", {tick_count[7:0], running, busy, tick, snap_valid, cfg_err},
              {8'd0, 5'b0});
        check("reset_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {2'b01, 19'd0});
        check("reset_snap_value", snap_value, 32'd0);

        start_lit(32'd100, 1'b1, 16'h0063, 16'h0000, 16'h0007);
        wait_tick(200, n);
        cyc(1);
        wait_tick(200, n);
        check("tick_spacing_2", n + 1, 32'd100);
        cyc(1);
        wait_tick(200, n);
        check("tick_spacing_3", n + 1, 32'd100);
        cyc(1);
        check("tick_count_3", tick_count, 32'd3);

        exp_q.push_back({3'd1, 1'b1, 16'h0008});
        exp_q.push_back({3'd0, 1'b1, 16'h0000});
        stop_req = 1'b1; cyc(1); stop_req = 1'b0;
        cyc(3);
        check("stopped", {running, busy, tick_count[7:0]}, {2'b00, 8'd3});

        start_lit(32'h0001_0005, 1'b0, 16'h0004, 16'h0001, 16'h0005);
        wait_tick(70000, n);
        cyc(1);
        check("oneshot_idle", {running, busy, tick_count[7:0]}, {2'b00, 8'd4});
        cyc(200);
        check("oneshot_single_tick", tick_count, 32'd4);

        cfg_period = 32'd1; start_req = 1'b1; cyc(1); start_req = 1'b0;
        check("cfg_err_pulse", {cfg_err, running, busy}, 3'b100);
        cyc(1);
        check("cfg_err_one_cycle", cfg_err, 1'b0);
        cfg_period = 32'd0; start_req = 1'b1; cyc(1); start_req = 1'b0;
        check("cfg_err_zero", cfg_err, 1'b1);
        cyc(5);
        check("cfg_err_no_start", {running, busy}, 2'b00);

        start_lit(32'd1000, 1'b1, 16'h03E7, 16'h0000, 16'h0007);
        cyc(200);
        push_snap();
        snap_req = 1'b1; cyc(1); snap_req = 1'b0;
        cyc(3);
        check("snap_rh_busy", {busy, snap_valid}, 2'b10);
        cyc(1);
        check("snap_done_4cyc", {snap_valid, snap_value < 32'd1000}, 2'b11);
        cyc(1);
        check("snap_back_run", {snap_valid, busy, running, snaps[3:0]}, {3'b001, 4'd1});

        n = 0;
        while (tcnt != 32'd2 && n < 2000) begin cyc(1); n++; end
        tc0 = tick_count;
        push_snap();
        snap_req = 1'b1; cyc(1); snap_req = 1'b0;
        cyc(2);
        check("irq_in_snap_rl", {tmr_irq, busy, tmr_address, tmr_write_n}, {2'b11, 3'd4, 1'b1});
        cyc(2);
        check("snap_done_irq", {snap_valid, tick}, 2'b10);
        cyc(2);
        check("irq_serviced", tick, 1'b1);
        cyc(1);
        check("irq_tick_plus1", tick_count, tc0 + 32'd1);
        cyc(50);
        check("irq_one_tick", tick_count, tc0 + 32'd1);

        tc0 = tick_count;
        exp_q.push_back({3'd1, 1'b1, 16'h0008});
        exp_q.push_back({3'd0, 1'b1, 16'h0000});
        push_snap();
        stop_req = 1'b1; snap_req = 1'b1; cyc(1); stop_req = 1'b0; snap_req = 1'b0;
        cyc(2);
        check("stop_clr_no_tick", {tick, tmr_address, tmr_write_n}, {1'b0, 3'd0, 1'b0});
        n = 0;
        while (!snap_valid && n < 10) begin cyc(1); n++; end
        check("stop_then_snap", {snap_valid, running}, 2'b10);
        cyc(1);
        check("stop_snap_end", {busy, running, snaps[3:0]}, {2'b00, 4'd3});
        check("stop_snap_no_tick", tick_count, tc0);
        cyc(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
